// File: rtl/piano_pkg.sv
// piano_pkg: note period table shared by the piano frequency divider and the tone decoder
package piano_pkg;
  localparam int PERIOD_W = 18;
  typedef enum logic [2:0] {DO4, RE4, MI4, FA4, SOL4, LA4, SI4, DO5} note_e;
  localparam logic [7:0][PERIOD_W-1:0] NOTE_PERIOD = {
    18'd95557, 18'd101239, 18'd113637, 18'd127553,
    18'd143173, 18'd151687, 18'd170263, 18'd191113
  };
  function automatic logic [7:0] note_match(input logic [PERIOD_W-1:0] p, input logic [PERIOD_W-1:0] tol);
    logic [PERIOD_W-1:0] d;
    note_match = '0;
    for (int i = 0; i < 8; i++) begin
      d = p >= NOTE_PERIOD[i] ? p - NOTE_PERIOD[i] : NOTE_PERIOD[i] - p;
      note_match[i] = d <= tol;
    end
  endfunction
endpackage

// File: rtl/tone_sync_edge.sv
// tone_sync_edge: 2-flop synchronizer plus registered rising-edge pulse
module tone_sync_edge (
  input  logic clk_in,
  input  logic rst_in,
  input  logic tone_in,
  output logic rise
);
  logic [2:0] s;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s <= '0;
      rise <= 1'b0;
    end else begin
      s <= {s[1:0], tone_in};
      rise <= s[1] & ~s[2];
    end
  end
endmodule

// File: rtl/tone_decoder.sv
// tone_decoder: measures tone period, classifies it against the note table and confirms the note
module tone_decoder import piano_pkg::*; #(
  parameter int TOL = 2000,
  parameter int CONFIRM = 2,
  parameter int MAX_PERIOD = 200000
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                tone_in,
  output logic [7:0]          note_out,
  output logic                note_valid,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_stb
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;
  localparam logic [PERIOD_W-1:0] ONE = 1;
  localparam logic [PERIOD_W-1:0] MAXP = PERIOD_W'(MAX_PERIOD);
  localparam logic [7:0] CONF = 8'(CONFIRM);
  logic rise;
  logic [0:0] state;
  logic [PERIOD_W-1:0] cnt;
  logic [7:0] cls, prev, run, nrun;
  tone_sync_edge u_sync (.clk_in(clk_in), .rst_in(rst_in), .tone_in(tone_in), .rise(rise));
  // classification runs on the freshly captured period, one cycle after the strobe
  always_comb begin
    cls = note_match(period_out, PERIOD_W'(TOL));
    nrun = cls != prev ? {7'd0, |cls} : (cls == 8'd0 ? 8'd0 : (run < CONF ? run + 8'd1 : run));
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt <= '0;
      period_out <= '0;
      period_stb <= 1'b0;
      note_out <= '0;
      note_valid <= 1'b0;
      prev <= '0;
      run <= '0;
    end else begin
      period_stb <= 1'b0;
      if (period_stb) begin
        prev <= cls;
        run <= nrun;
        if (|cls && nrun >= CONF) begin
          note_out <= cls;
          note_valid <= 1'b1;
        end else if (cls != prev) begin
          note_out <= '0;
          note_valid <= 1'b0;
        end
      end
      // an edge coinciding with saturation is still a valid period, so rise wins over timeout
      if (state == IDLE) begin
        cnt <= rise ? ONE : '0;
        state <= rise ? MEASURE : IDLE;
      end else if (rise) begin
        period_out <= cnt;
        period_stb <= 1'b1;
        cnt <= ONE;
      end else if (cnt == MAXP) begin
        state <= IDLE;
        cnt <= '0;
        period_out <= '0;
        note_out <= '0;
        note_valid <= 1'b0;
        prev <= '0;
        run <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end
endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: directed sequences with random jitter checked against a period/history model
module tb_tone_decoder;
  localparam int TOL = 2000;
  localparam int CONFIRM = 2;
  localparam int MAXP = 200000;
  localparam int PER[8] = '{191113, 170263, 151687, 143173, 127553, 113637, 101239, 95557};
  logic clk_in = 1'b0;
  logic rst_in, tone_in;
  logic [7:0] note_out;
  logic note_valid, period_stb;
  logic [17:0] period_out;
  int n_tests = 0, n_fail = 0;
  bit active;
  int prev_p, mdl_period;
  logic [7:0] hist[$];
  tone_decoder #(.TOL(TOL), .CONFIRM(CONFIRM), .MAX_PERIOD(MAXP)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .tone_in(tone_in), .note_out(note_out),
    .note_valid(note_valid), .period_out(period_out), .period_stb(period_stb)
  );
  always #10 clk_in = ~clk_in;
  function automatic logic [7:0] ref_class(input int p);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      int d = p > PER[i] ? p - PER[i] : PER[i] - p;
      if (d <= TOL) r[i] = 1'b1;
    end
    return r;
  endfunction
  function automatic logic [7:0] exp_note();
    logic [7:0] h;
    if (hist.size() < CONFIRM) return 8'd0;
    h = hist[hist.size()-1];
    for (int k = 2; k <= CONFIRM; k++) if (hist[hist.size()-k] != h) return 8'd0;
    return h;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic mdl_reset();
    active = 0;
    hist.delete();
    mdl_period = 0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_note"}, note_out, 0);
    chk({tag, "_valid"}, note_valid, 0);
    chk({tag, "_period"}, period_out, 0);
    chk({tag, "_stb"}, period_stb, 0);
  endtask
  // one rising edge followed by a period of p cycles; optional reset at rst_at, optional silence check
  task automatic send(input int p, input int rst_at, input bit sil);
    bit stb = active;
    if (active) begin
      mdl_period = prev_p;
      hist.push_back(ref_class(prev_p));
    end
    active = 1;
    prev_p = p;
    tone_in = 1'b1;
    for (int c = 0; c < p; c++) begin
      @(posedge clk_in); #1;
      if (c == 9) tone_in = 1'b0;
      if (c == 3) begin
        chk("stb", period_stb, stb);
        chk("period", period_out, mdl_period);
      end
      if (c == 4) begin
        chk("stb_pulse", period_stb, 0);
        chk("note", note_out, exp_note());
        chk("valid", note_valid, exp_note() != 0);
      end
      if (!sil && rst_at == 0 && c == p - 1) begin
        chk("note_hold", note_out, exp_note());
        chk("valid_hold", note_valid, exp_note() != 0);
      end
      if (sil && c == MAXP + 2) chk("sil_before", note_valid, exp_note() != 0);
      if (sil && c == MAXP + 3) begin
        mdl_reset();
        chk_zero("silence");
      end
      if (rst_at != 0 && c == rst_at) rst_in = 1'b1;
      if (rst_at != 0 && c == rst_at + 1) begin
        rst_in = 1'b0;
        mdl_reset();
        chk_zero("midreset");
        break;
      end
    end
  endtask
  initial begin
    int j, n;
    rst_in = 1'b1;
    tone_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk_zero("reset");
    rst_in = 1'b0;
    mdl_reset();
    @(posedge clk_in); #1;
    repeat (3) send(PER[0], 0, 0);
    send(PER[0], 12, 0);
    for (int k = 0; k < 4; k++) begin
      j = $urandom_range(0, 1500);
      send(k % 2 == 0 ? PER[5] + j : PER[5] - j, 0, 0);
    end
    send(PER[5], 12, 0);
    repeat (3) send($urandom_range(155000, 166000), 0, 0);
    send(160000, 12, 0);
    repeat (3) send(PER[2], 0, 0);
    repeat (2) send(PER[3], 0, 0);
    send(PER[3], 12, 0);
    repeat (3) send(PER[4], 0, 0);
    send(MAXP + 4, 0, 1);
    send(PER[7], 40000, 0);
    repeat (2) send(PER[7] + $urandom_range(0, 1000), 0, 0);
    send(PER[7], 12, 0);
    n = $urandom_range(0, 7);
    repeat (3) send(PER[n] + $urandom_range(0, 2 * TOL) - TOL, 0, 0);
    send(PER[n], 12, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
